// File: rtl/seg_pkg.sv
// Shared constants and BCD-to-segment encoding for the multiplexed display driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Non-BCD codes 10..15 render as a dash so bad data is visible rather than garbled.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational digit decoder: one BCD digit plus blank flag to an active-low segment vector.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_encode(digit);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner for two 4-digit BCD values, with a
// per-frame shadow snapshot for tear-free display. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dv10,
  input  logic [3:0] dv11,
  input  logic [3:0] dv12,
  input  logic [3:0] dv13,
  input  logic [3:0] dv20,
  input  logic [3:0] dv21,
  input  logic [3:0] dv22,
  input  logic [3:0] dv23,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [2:0]            idx;
  logic                  active;
  logic [3:0]            shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  run_zero;
  logic [3:0]            cur_digit;
  logic [6:0]            seg_next;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outputs stay dark after reset until the first slot boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      active     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick && (idx == 3'd7);
      if (tick) begin
        idx    <= idx + 3'd1;
        active <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 4'd0;
      end
    end else if (tick && (idx == 3'd7)) begin
      shadow[0] <= dv10;
      shadow[1] <= dv11;
      shadow[2] <= dv12;
      shadow[3] <= dv13;
      shadow[4] <= dv20;
      shadow[5] <= dv21;
      shadow[6] <= dv22;
      shadow[7] <= dv23;
    end
  end

  // A digit blanks only while it and every higher digit of its value are zero.
  always_comb begin
    lz_blank = '0;
    run_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int v = 0; v < 2; v++) begin
      run_zero = 1'b1;
      for (int p = 3; p >= 1; p--) begin
        run_zero           = run_zero && (shadow[4*v+p] == 4'd0);
        lz_blank[4*v+p]    = run_zero;
      end
    end
`endif
  end

  assign cur_digit = shadow[idx];

  seg_decode u_decode (
    .digit (cur_digit),
    .blank (lz_blank[idx]),
    .seg   (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else if (active) begin
      an  <= ~(8'd1 << idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver at CLK_DIV=4: a slot/frame arithmetic model
// compared every cycle, plus directed literal checks on scan order, snapshots and reset.
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dv10, dv11, dv12, dv13, dv20, dv21, dv22, dv23;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .dv10(dv10), .dv11(dv11), .dv12(dv12), .dv13(dv13),
    .dv20(dv20), .dv21(dv21), .dv22(dv22), .dv23(dv23),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  int         n = 0;            // clock edges since reset release
  int         mi;
  logic [3:0] sh [8];
  logic [7:0] exp_an  = 8'hFF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_ft  = 1'b0;
  bit         model_live = 1'b0;

  function automatic logic [6:0] code_of(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return t[d];
  endfunction

  function automatic logic [6:0] model_seg(input int i);
    int  v;
    int  p;
    bit  blank;
    v = i / 4;
    p = i % 4;
    blank = 1'b0;
    if (LZB && p > 0) begin
      blank = 1'b1;
      for (int q = p; q < 4; q++)
        if (sh[v*4+q] != 4'd0) blank = 1'b0;
    end
    return blank ? 7'h7F : code_of(sh[i]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      for (int k = 0; k < 8; k++) sh[k] = 4'd0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_ft  = 1'b0;
      model_live = 1'b1;
    end else begin
      // Slot s covers edges 4s..4s+3 after release; display lags the slot by one edge.
      if (n >= DIV) begin
        mi      = (n / DIV) % 8;
        exp_an  = ~(8'd1 << mi);
        exp_seg = model_seg(mi);
      end
      exp_ft = ((n + 1) % (8 * DIV) == 0);
      if (exp_ft) begin
        sh[0] = dv10; sh[1] = dv11; sh[2] = dv12; sh[3] = dv13;
        sh[4] = dv20; sh[5] = dv21; sh[6] = dv22; sh[7] = dv23;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL model_compare t=%0t got an=%h seg=%h ft=%b want an=%h seg=%h ft=%b",
                 $time, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wait_an(input logic [7:0] a, input logic [6:0] s, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (an === a) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting an=%h", nm, a);
    end else begin
      chk(nm, int'(seg), int'(s));
    end
  endtask

  task automatic wait_ft(input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting frame_tick", nm);
    end
  endtask

  task automatic restart_probe(input string nm, input logic [6:0] slot1_seg);
    int ft_at = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) chk({nm, "_dark_before_tick"}, int'(an), 8'hFF);
      if (i == 5) begin
        chk({nm, "_first_slot_an"}, int'(an), 8'hFD);
        chk({nm, "_first_slot_seg"}, int'(seg), int'(slot1_seg));
      end
      if (frame_tick === 1'b1 && ft_at == 0) ft_at = i;
    end
    chk({nm, "_first_frame_tick_cycle"}, ft_at, 32);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    {dv13, dv12, dv11, dv10} = {4'd1, 4'd2, 4'd3, 4'd4};
    {dv23, dv22, dv21, dv20} = {4'd0, 4'd5, 4'd6, 4'd7};
    repeat (3) @(negedge clk);
    chk("reset_an", int'(an), 8'hFF);
    chk("reset_seg", int'(seg), 7'h7F);
    chk("reset_ft", int'(frame_tick), 0);
    rst = 1'b0;
    // Shadow is zero before the first snapshot: tens slot shows 0 or blank.
    restart_probe("release", LZB ? 7'h7F : 7'h40);

    wait_an(8'hFE, 7'h19, "v1_units_4");
    wait_an(8'hFD, 7'h30, "v1_tens_3");
    wait_an(8'hFB, 7'h24, "v1_hund_2");
    wait_an(8'hF7, 7'h79, "v1_thou_1");
    wait_an(8'hEF, 7'h78, "v2_units_7");
    wait_an(8'hDF, 7'h02, "v2_tens_6");
    wait_an(8'hBF, 7'h12, "v2_hund_5");
    wait_an(8'h7F, LZB ? 7'h7F : 7'h40, "v2_thou_0");

    // Tear-free: a mid-frame change lands only at the next snapshot.
    wait_an(8'hFB, 7'h24, "idx2_before_change");
    dv10 = 4'd9;
    wait_ft("ft_after_change");
    dv10 = 4'd5;
    wait_an(8'hFE, 7'h10, "units_after_snapshot_9");
    wait_ft("ft_second");
    wait_an(8'hFE, 7'h12, "units_next_frame_5");

    // Dash digit counts as non-zero for leading-zero blanking.
    {dv13, dv12, dv11, dv10} = {4'd0, 4'd12, 4'd0, 4'd1};
    wait_ft("ft_dash");
    wait_an(8'hFE, 7'h79, "dash_units_1");
    wait_an(8'hFD, 7'h40, "zero_below_dash");
    wait_an(8'hFB, 7'h3F, "dash_shown");
    wait_an(8'hF7, LZB ? 7'h7F : 7'h40, "thou_zero_above_dash");

    {dv23, dv22, dv21, dv20} = 16'h0000;
    wait_ft("ft_v2_zero");
    wait_an(8'hEF, 7'h40, "v2_zero_units");
    wait_an(8'hDF, LZB ? 7'h7F : 7'h40, "v2_zero_tens");
    wait_an(8'hBF, LZB ? 7'h7F : 7'h40, "v2_zero_hund");
    wait_an(8'h7F, LZB ? 7'h7F : 7'h40, "v2_zero_thou");

    // Mid-frame reset at idx 5.
    wait_an(8'hDF, LZB ? 7'h7F : 7'h40, "pre_reset_idx5");
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_an", int'(an), 8'hFF);
    chk("midreset_seg", int'(seg), 7'h7F);
    chk("midreset_ft", int'(frame_tick), 0);
    rst = 1'b0;
    restart_probe("midreset", LZB ? 7'h7F : 7'h40);
    wait_an(8'hFD, 7'h40, "after_midreset_tens_0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, clock cycles per digit slot; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have ports dv10, dv11, dv12, dv13, each input, 4 bits: value-1 BCD digits, in order units, tens, hundreds, thousands.
REQ-005 The block SHALL have ports dv20, dv21, dv22, dv23, each input, 4 bits: value-2 BCD digits, same order.
REQ-006 The block SHALL have port an, output, 8 bits: digit enables, active-low; an[0] is the value-1 units digit and an[7] is the value-2 thousands digit.
REQ-007 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-008 The block SHALL have port frame_tick, output, 1 bit: a one-cycle pulse marking the start of a new frame.

Function
REQ-009 Prescaler: counts 0 to CLK_DIV-1 and wraps to 0; a "tick" is the cycle in which count equals CLK_DIV-1.
REQ-010 Digit index idx (0..7): advances by 1 on each tick and wraps from 7 to 0.
REQ-011 Snapshot: on a tick with idx=7, all eight inputs SHALL be latched into shadow registers, and frame_tick SHALL be 1 in the following cycle only.
REQ-012 Input changes between snapshots SHALL NOT affect the display (tear-free).
REQ-013 Mapping: idx 0..3 selects shadow dv10..dv13; idx 4..7 selects shadow dv20..dv23.
REQ-014 an and seg SHALL be registered and reflect the current idx and shadow with one cycle of latency; exactly one an bit is low outside reset.
REQ-015 Segment codes: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-016 Digits 10..15 SHALL display a dash, 0x3F (g segment only).
REQ-017 A blank digit SHALL drive seg=0x7F while its an bit remains low.

Reset
REQ-018 While rst=1, at each clock edge: prescaler=0, idx=0, all shadow digits=0, an=0xFF, seg=0x7F, frame_tick=0.
REQ-019 After rst deasserts, the first tick SHALL occur CLK_DIV cycles later; the first snapshot SHALL occur at the 8th tick.
REQ-020 Assertion of rst mid-scan SHALL take effect at the next edge regardless of state.

Configuration
REQ-021 With macro LEADING_ZERO_BLANK_EN defined, a thousands, hundreds or tens digit SHALL be blank when it and all higher digits of the same value are 0.
REQ-022 Under LEADING_ZERO_BLANK_EN, the units digit SHALL never be blanked, and a dash digit (10..15) counts as non-zero.
REQ-023 Without LEADING_ZERO_BLANK_EN, every digit SHALL be displayed per REQ-015 and REQ-016.

Structure
REQ-024 Shared package seg_pkg SHALL hold: the segment code constants (including SEG_BLANK=0x7F and SEG_DASH=0x3F), NUM_DIGITS=8, and the BCD-to-segment encode function.
REQ-025 The design SHALL contain one combinational sub-module, seg_decode (4-bit digit plus blank flag to 7-bit seg); the prescaler, index, shadow registers and output registers stay in the top module.

Verification (CLK_DIV=4)
REQ-026 Hold rst=1 for 3 cycles, then release -> an=0xFF and seg=0x7F until the first tick; frame_tick first pulses after the 8th tick (cycle 32 after release).
REQ-027 v1 digits 4,3,2,1 (value 1234) and v2 digits 7,6,5,0 (value 0567), after one frame -> an=0xFE with seg=0x19; an=0xFD with 0x30; an=0xFB with 0x24; an=0xF7 with 0x79; an=0xEF with 0x78; then 0x02, 0x12; an=0x7F with 0x40 (without the macro) or 0x7F (with the macro).
REQ-028 Change dv10 from 4 to 9 while idx=2 -> seg for an[0] stays 0x19 until after the next frame_tick, then becomes 0x10.
REQ-029 dv12=12 -> 0x3F shown at an=0xFB; with the macro, a zero dv11 still displays 0x40.
REQ-030 With the macro, v2=0000 -> an[7:5] slots show 0x7F and an[4] shows 0x40.
REQ-031 Assert rst for 1 cycle mid-frame at idx=5 -> next cycle an=0xFF, seg=0x7F, shadow cleared; the scan restarts from idx=0.
